// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline sequencing controller for the 5-stage core. It produces load
// enables and bubble/flush controls for the PC, IF/ID, ID/EXE, EXE/MEM and
// MEM/WB registers.
//
// Three hazard sources are handled, highest priority first:
//   1. multi-cycle data-memory access (freeze the front of the pipe, bubble WB)
//   2. taken branch in EXE (flush the two wrong-path slots)
//   3. load-use dependency (hold PC/IF-ID for one cycle, bubble into EXE)
// A data-memory wait is bounded by MEM_TIMEOUT. Once the bound is reached the
// pipe is released anyway, the result is dropped and mem_err is latched.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   id_rs1, id_rs2     source registers of the instruction in ID
//   id_use_rs2         ID instruction reads rs2
//   ex_waddr           destination register of the instruction in EXE
//   ex_wen             EXE instruction writes a register
//   ex_memtoReg        EXE instruction is a load
//   ex_branch_taken    branch in EXE resolved taken
//   mem_req            MEM-stage instruction accesses data memory
//   dmem_ready         data memory completes the access this cycle
//   dmem_req           request to data memory
//   pc_en .. memwb_en  pipeline register load enables
//   ifid_flush         force a bubble into IF/ID
//   idex_flush         force a bubble into ID/EXE
//   memwb_bubble       force a bubble into MEM/WB
//   state              0 = RUN, 1 = MEM_WAIT
//   mem_err            sticky data-memory timeout flag
//   stall_cnt          saturating count of cycles with pc_en = 0
module pipe_hazard_ctrl #(
    parameter int ASIZE       = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] id_rs1,
    input  logic [ASIZE-1:0] id_rs2,
    input  logic             id_use_rs2,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic             ex_wen,
    input  logic             ex_memtoReg,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic             mem_err,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       mem_err_next;

    logic mem_stall;
    logic timeout;
    logic load_use;

    assign state = cur_state;

    assign mem_stall = mem_req & ~dmem_ready;

    // Only a wait that is still unready at the bound counts as a timeout.
    assign timeout = (cur_state == MEM_WAIT) && mem_stall && (wait_cnt == TIMEOUT_CNT);

    assign load_use = ex_memtoReg && ex_wen && (ex_waddr != '0) &&
                      ((ex_waddr == id_rs1) || (id_use_rs2 && (ex_waddr == id_rs2)));

    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        memwb_bubble  = 1'b0;
        dmem_req      = mem_req;
        next_state    = RUN;
        wait_cnt_next = 8'd0;
        mem_err_next  = mem_err;

        if (rst) begin
            // Hold the whole pipe quiet while in reset.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            dmem_req = 1'b0;
        end else if (mem_stall && !timeout) begin
            // Freeze everything upstream of MEM; keep WB clocking but with a
            // bubble so the stalled instruction is not written back twice.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            dmem_req     = 1'b1;
            next_state   = MEM_WAIT;
            if (cur_state == RUN) begin
                wait_cnt_next = 8'd1;
            end else begin
                wait_cnt_next = wait_cnt + 8'd1;
            end
        end else begin
            if (timeout) begin
                // Forced release: the memory result never arrived, drop it.
                memwb_bubble = 1'b1;
                mem_err_next = 1'b1;
            end
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= RUN;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            cur_state <= next_state;
            wait_cnt  <= wait_cnt_next;
            mem_err   <= mem_err_next;
            if (!pc_en && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
// Inputs change on the falling edge; outputs are sampled 2 time units later,
// well before the next rising edge. Every expected output word is queued when
// its stimulus is applied and popped when the sample is taken.
module tb_pipe_hazard_ctrl;

    localparam int ASIZE       = 5;
    localparam int MEM_TIMEOUT = 4;

    // {dmem_req, pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, memwb_bubble}
    localparam logic [8:0] C_IDLE = 9'b0_11111_000;
    localparam logic [8:0] C_LU   = 9'b0_00111_010;
    localparam logic [8:0] C_BR   = 9'b0_11111_110;
    localparam logic [8:0] C_MEM  = 9'b1_00001_001;
    localparam logic [8:0] C_REL  = 9'b1_11111_000;
    localparam logic [8:0] C_TO   = 9'b1_11111_001;

    typedef struct packed {
        logic       mreq;
        logic       rdy;
        logic       br;
        logic       m2r;
        logic       wen;
        logic [4:0] wa;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u2;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [8:0] ctl;
        logic [1:0] st;
    } step_t;

    typedef struct {
        string       name;
        logic [27:0] v;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [ASIZE-1:0] id_rs1;
    logic [ASIZE-1:0] id_rs2;
    logic             id_use_rs2;
    logic [ASIZE-1:0] ex_waddr;
    logic             ex_wen;
    logic             ex_memtoReg;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             dmem_ready;
    logic             dmem_req;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_bubble;
    logic [1:0]       state;
    logic             mem_err;
    logic [15:0]      stall_cnt;

    logic [27:0] obs;
    exp_t        sb[$];
    int          n_tests;
    int          n_fail;
    logic        exp_err;
    logic [15:0] exp_stall;

    pipe_hazard_ctrl #(
        .ASIZE      (ASIZE),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs2     (id_use_rs2),
        .ex_waddr       (ex_waddr),
        .ex_wen         (ex_wen),
        .ex_memtoReg    (ex_memtoReg),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .dmem_ready     (dmem_ready),
        .dmem_req       (dmem_req),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .memwb_bubble   (memwb_bubble),
        .state          (state),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt)
    );

    assign obs = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, memwb_bubble, state, mem_err, stall_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic mreq, input logic rdy, input logic br,
                                 input logic m2r, input logic wen, input logic [4:0] wa,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic u2);
        mk = '{mreq: mreq, rdy: rdy, br: br, m2r: m2r, wen: wen,
               wa: wa, r1: r1, r2: r2, u2: u2};
    endfunction

    function automatic step_t mks(input stim_t s, input logic [8:0] ctl, input logic [1:0] st);
        mks = '{s: s, ctl: ctl, st: st};
    endfunction

    task automatic apply(input stim_t s);
        mem_req         = s.mreq;
        dmem_ready      = s.rdy;
        ex_branch_taken = s.br;
        ex_memtoReg     = s.m2r;
        ex_wen          = s.wen;
        ex_waddr        = s.wa;
        id_rs1          = s.r1;
        id_rs2          = s.r2;
        id_use_rs2      = s.u2;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        apply(mk(1, 0, 1, 1, 1, 5'd3, 5'd3, 5'd0, 0));
        sb.push_back('{"reset_outputs", 28'h0});
        #2;
        e = sb.pop_front();
        n_tests++;
        if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", e.name, obs, e.v);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_err   = 1'b0;
        exp_stall = 16'd0;
        apply(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0));
    endtask

    task automatic test_load_use();
        step_t t[$];
        exp_t  e;
        t.push_back(mks(mk(0, 0, 0, 1, 1, 5'd3, 5'd3, 5'd0, 0), C_LU, 2'd0));
        t.push_back(mks(mk(0, 0, 0, 0, 0, 5'd0, 5'd3, 5'd0, 0), C_IDLE, 2'd0));
        t.push_back(mks(mk(0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 0), C_IDLE, 2'd0));
        foreach (t[i]) begin
            apply(t[i].s);
            sb.push_back('{$sformatf("load_use[%0d]", i), {t[i].ctl, t[i].st, exp_err, exp_stall}});
            #2;
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (!t[i].ctl[7]) exp_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_rs2_gating();
        step_t t[$];
        exp_t  e;
        t.push_back(mks(mk(0, 0, 0, 1, 1, 5'd4, 5'd1, 5'd4, 0), C_IDLE, 2'd0));
        t.push_back(mks(mk(0, 0, 0, 1, 1, 5'd4, 5'd1, 5'd4, 1), C_LU, 2'd0));
        t.push_back(mks(mk(0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd4, 1), C_IDLE, 2'd0));
        foreach (t[i]) begin
            apply(t[i].s);
            sb.push_back('{$sformatf("rs2_gating[%0d]", i), {t[i].ctl, t[i].st, exp_err, exp_stall}});
            #2;
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (!t[i].ctl[7]) exp_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch_load_use();
        step_t t[$];
        exp_t  e;
        t.push_back(mks(mk(0, 0, 1, 1, 1, 5'd3, 5'd3, 5'd0, 0), C_BR, 2'd0));
        t.push_back(mks(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_IDLE, 2'd0));
        foreach (t[i]) begin
            apply(t[i].s);
            sb.push_back('{$sformatf("branch_lu[%0d]", i), {t[i].ctl, t[i].st, exp_err, exp_stall}});
            #2;
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (!t[i].ctl[7]) exp_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_mem_wait();
        step_t t[$];
        exp_t  e;
        t.push_back(mks(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_MEM, 2'd0));
        t.push_back(mks(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_MEM, 2'd1));
        t.push_back(mks(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_MEM, 2'd1));
        t.push_back(mks(mk(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_REL, 2'd1));
        t.push_back(mks(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_IDLE, 2'd0));
        foreach (t[i]) begin
            apply(t[i].s);
            sb.push_back('{$sformatf("mem_wait[%0d]", i), {t[i].ctl, t[i].st, exp_err, exp_stall}});
            #2;
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (!t[i].ctl[7]) exp_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        step_t t[$];
        exp_t  e;
        for (int k = 0; k < 4; k++) begin
            t.push_back(mks(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_MEM, (k == 0) ? 2'd0 : 2'd1));
        end
        t.push_back(mks(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_TO, 2'd1));
        t.push_back(mks(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_IDLE, 2'd0));
        t.push_back(mks(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_IDLE, 2'd0));
        foreach (t[i]) begin
            apply(t[i].s);
            sb.push_back('{$sformatf("timeout[%0d]", i), {t[i].ctl, t[i].st, exp_err, exp_stall}});
            #2;
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (!t[i].ctl[7]) exp_stall++;
            if (t[i].ctl == C_TO) exp_err = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_priority();
        step_t t[$];
        exp_t  e;
        t.push_back(mks(mk(1, 0, 1, 1, 1, 5'd3, 5'd3, 5'd0, 0), C_MEM, 2'd0));
        t.push_back(mks(mk(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_REL, 2'd1));
        t.push_back(mks(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_IDLE, 2'd0));
        foreach (t[i]) begin
            apply(t[i].s);
            sb.push_back('{$sformatf("priority[%0d]", i), {t[i].ctl, t[i].st, exp_err, exp_stall}});
            #2;
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (!t[i].ctl[7]) exp_stall++;
            @(negedge clk);
        end
    endtask

    // Release followed at once by a new unready request: the wait counter must
    // restart at 1, so the timeout lands exactly MEM_TIMEOUT stalls later.
    task automatic test_back_to_back();
        step_t t[$];
        exp_t  e;
        t.push_back(mks(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_MEM, 2'd0));
        t.push_back(mks(mk(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_REL, 2'd1));
        for (int k = 0; k < 4; k++) begin
            t.push_back(mks(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_MEM, (k == 0) ? 2'd0 : 2'd1));
        end
        t.push_back(mks(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_TO, 2'd1));
        t.push_back(mks(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_IDLE, 2'd0));
        foreach (t[i]) begin
            apply(t[i].s);
            sb.push_back('{$sformatf("back_to_back[%0d]", i), {t[i].ctl, t[i].st, exp_err, exp_stall}});
            #2;
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (!t[i].ctl[7]) exp_stall++;
            if (t[i].ctl == C_TO) exp_err = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_wait();
        step_t t[$];
        exp_t  e;
        t.push_back(mks(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_MEM, 2'd0));
        t.push_back(mks(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_MEM, 2'd1));
        foreach (t[i]) begin
            apply(t[i].s);
            sb.push_back('{$sformatf("pre_reset[%0d]", i), {t[i].ctl, t[i].st, exp_err, exp_stall}});
            #2;
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (!t[i].ctl[7]) exp_stall++;
            @(negedge clk);
        end
        // Still stalled in MEM_WAIT; assert reset between clock edges.
        #2;
        rst = 1'b1;
        exp_err   = 1'b0;
        exp_stall = 16'd0;
        sb.push_back('{"reset_mid_wait", 28'h0});
        #1;
        e = sb.pop_front();
        n_tests++;
        if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", e.name, obs, e.v);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0));
        sb.push_back('{"after_reset", {C_REL, 2'd0, exp_err, exp_stall}});
        #2;
        e = sb.pop_front();
        n_tests++;
        if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", e.name, obs, e.v);
        end
        @(negedge clk);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_err   = 1'b0;
        exp_stall = 16'd0;
        test_reset();
        test_load_use();
        test_rs2_gating();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_priority();
        test_back_to_back();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
